// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Brief    : Drives a DSP48A1 slice as an unsigned N-term dot-product engine
//            with valid/ready operand and result ports.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int N       = 8,
  parameter int DSP_LAT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  input  logic [47:0] DSP_P
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N - 1);

  // X=M/Z=0 starts a vector, X=M/Z=P accumulates, X=0/Z=P holds, X=0/Z=0 clears
  localparam logic [7:0] C_OPM_FIRST = 8'h01;
  localparam logic [7:0] C_OPM_ACCUM = 8'h09;
  localparam logic [7:0] C_OPM_HOLD  = 8'h08;
  localparam logic [7:0] C_OPM_CLEAR = 8'h00;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  tag_t             tag_q [1:DSP_LAT];
  tag_t             tag_d;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [47:0]      res_data_q;
  logic [17:0]      dsp_a_q;
  logic [17:0]      dsp_b_q;
  logic [7:0]       dsp_opmode_q;
  logic             accept;
  logic             is_last;

  assign accept  = in_valid & in_ready_q;
  assign is_last = (cnt_q == C_LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = is_last ? '0 : cnt_q + 1'b1;
    end
    tag_d.vld   = accept;
    tag_d.first = accept & (cnt_q == '0);
    tag_d.last  = accept & is_last;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      for (int i = 1; i <= DSP_LAT; i++) begin
        tag_q[i] <= '0;
      end
      in_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      dsp_opmode_q <= C_OPM_CLEAR;
    end else begin
      cnt_q    <= cnt_d;
      tag_q[1] <= tag_d;
      for (int i = 2; i <= DSP_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      if (accept) begin
        dsp_a_q <= in_a;
        dsp_b_q <= in_b;
      end

      // The slice registers OPMODE once more, so it lines up with M at P
      if (tag_q[1].vld) begin
        dsp_opmode_q <= tag_q[1].first ? C_OPM_FIRST : C_OPM_ACCUM;
      end else begin
        dsp_opmode_q <= C_OPM_HOLD;
      end

      case (state_q)
        ACCUM: begin
          if (accept && is_last) begin
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (tag_q[DSP_LAT].vld && tag_q[DSP_LAT].last) begin
            res_data_q  <= DSP_P;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign DSP_A      = dsp_a_q;
  assign DSP_B      = dsp_b_q;
  assign DSP_OPMODE = dsp_opmode_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Brief    : Self-checking bench for dsp_mac_sequencer with a DSP48A1 slice model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

  localparam int N     = 4;
  localparam int LIMIT = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [47:0] res_data;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic [47:0] DSP_P;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.N(N), .DSP_LAT(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .DSP_A      (DSP_A),
    .DSP_B      (DSP_B),
    .DSP_OPMODE (DSP_OPMODE),
    .DSP_P      (DSP_P)
  );

  // DSP48A1 slice: A1/B1 -> M -> P with registered OPMODE, CEs tied high
  logic [17:0] s_a1  = '0;
  logic [17:0] s_b1  = '0;
  logic [35:0] s_m   = '0;
  logic [7:0]  s_opm = '0;
  logic [47:0] s_p   = '0;
  logic [47:0] s_x;
  logic [47:0] s_z;

  assign s_x   = (s_opm[1:0] == 2'b01) ? {12'b0, s_m} : 48'd0;
  assign s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  assign DSP_P = s_p;

  always @(posedge CLK) begin
    s_a1  <= DSP_A;
    s_b1  <= DSP_B;
    s_m   <= {18'b0, s_a1} * {18'b0, s_b1};
    s_opm <= DSP_OPMODE;
    s_p   <= s_x + s_z;
  end

  // Result monitor: records each consumed result and its accept-to-valid latency
  int          cyc = 0;
  int          acc_n = 0;
  int          last_acc_edge = 0;
  int          rise_edge = 0;
  logic        rv_prev = 1'b0;
  logic [47:0] got_q [$];
  int          lat_q [$];

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rv_prev <= res_valid;
    if (RST) begin
      acc_n <= 0;
    end else begin
      if (in_valid && in_ready) begin
        if (acc_n == N - 1) begin
          acc_n         <= 0;
          last_acc_edge <= cyc;
        end else begin
          acc_n <= acc_n + 1;
        end
      end
      if (res_valid && !rv_prev) rise_edge <= cyc - 1;
      if (res_valid && res_ready) begin
        got_q.push_back(res_data);
        lat_q.push_back(((res_valid && !rv_prev) ? cyc - 1 : rise_edge) - last_acc_edge);
      end
    end
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves in_valid high after the accepting edge
  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int t = 0;
    while (!in_ready && t < LIMIT) begin
      @(negedge CLK);
      t++;
    end
    chk("send_ready", {47'b0, in_ready}, 48'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic get_result(input string tag, input logic [47:0] exp);
    int t = 0;
    logic [47:0] d;
    int l;
    while (got_q.size() == 0 && t < LIMIT) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    assert (got_q.size() !== 0) else begin
      n_fail++;
      $error("FAIL %s: observed no result after %0d cycles expected %0h", tag, t, exp);
    end
    if (got_q.size() != 0) begin
      d = got_q.pop_front();
      l = lat_q.pop_front();
      chk(tag, d, exp);
      chk({tag, "_lat"}, 48'(l), 48'd4);
    end
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    RST      = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    got_q.delete();
    lat_q.delete();
  endtask

  logic [17:0] va [N];
  logic [17:0] vb [N];
  logic [47:0] exp_sum;
  logic [47:0] held;

  initial begin
    // Reset values while RST is held
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", {47'b0, in_ready}, 48'd1);
    chk("rst_res_valid", {47'b0, res_valid}, 48'd0);
    chk("rst_res_data", res_data, 48'd0);
    chk("rst_opmode", {40'b0, DSP_OPMODE}, 48'h00);
    chk("rst_dsp_a", {30'b0, DSP_A}, 48'd0);
    do_reset(1);

    // a=1..4, b=2 back to back, with slice control checks
    res_ready = 1'b1;
    send(18'd1, 18'd2);
    chk("t1_dsp_a", {30'b0, DSP_A}, 48'd1);
    chk("t1_opm_idle", {40'b0, DSP_OPMODE}, 48'h08);
    send(18'd2, 18'd2);
    chk("t1_opm_first", {40'b0, DSP_OPMODE}, 48'h01);
    send(18'd3, 18'd2);
    chk("t1_opm_accum", {40'b0, DSP_OPMODE}, 48'h09);
    send(18'd4, 18'd2);
    chk("t1_in_ready_low", {47'b0, in_ready}, 48'd0);
    idle(0);
    get_result("seq_1234", 48'd20);

    // Same data with a bubble after every term
    for (int i = 0; i < N; i++) begin
      send(18'(i + 1), 18'd2);
      idle(1);
    end
    get_result("bubbles", 48'd20);

    // Full-scale operands
    for (int i = 0; i < N; i++) send(18'h3FFFF, 18'h3FFFF);
    idle(0);
    get_result("max", 48'h003FFFE00004);

    // Result stall: res_valid/res_data held, in_ready low
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) send(18'd7, 18'd3);
    idle(6);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {47'b0, res_valid}, 48'd1);
      chk("stall_data", res_data, 48'd84);
      chk("stall_in_ready", {47'b0, in_ready}, 48'd0);
      @(negedge CLK);
    end
    chk("stall_none_consumed", 48'(got_q.size()), 48'd0);
    res_ready = 1'b1;
    get_result("stall", 48'd84);
    for (int i = 0; i < N; i++) send(18'd1, 18'd1);
    idle(0);
    get_result("after_stall", 48'd4);

    // Reset mid-vector discards the partial sum
    send(18'd9, 18'd9);
    send(18'd9, 18'd9);
    idle(0);
    do_reset(4);
    idle(12);
    chk("abort_no_result", 48'(got_q.size()), 48'd0);
    chk("abort_res_valid", {47'b0, res_valid}, 48'd0);
    for (int i = 0; i < N; i++) send(18'd5, 18'd5);
    idle(0);
    get_result("after_abort", 48'd100);

    // Back-to-back vectors keep order
    for (int i = 0; i < N; i++) send(18'd1, 18'd1);
    for (int i = 0; i < N; i++) send(18'd2, 18'd3);
    idle(0);
    get_result("b2b_first", 48'd4);
    get_result("b2b_second", 48'd24);

    // Random vectors with random bubbles and result stalls
    for (int v = 0; v < 8; v++) begin
      exp_sum = '0;
      for (int i = 0; i < N; i++) begin
        va[i]   = 18'($urandom);
        vb[i]   = 18'($urandom);
        exp_sum = exp_sum + 48'(va[i]) * 48'(vb[i]);
      end
      res_ready = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        send(va[i], vb[i]);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 8));
      res_ready = 1'b1;
      get_result("random", exp_sum);
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
